// File: rtl/regfile_pkg.sv
// Shared types and helpers for the scoreboarded register file.
package regfile_pkg;

    // Default geometry of the register file.
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Index of the optional hard-wired zero register.
    localparam int ZERO_IDX = 0;

    // One register word at the default width.
    typedef logic [DEF_WIDTH-1:0] reg_word_t;

    // Address width that never collapses to zero bits, even for tiny depths.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: issue marks a destination pending, writeback clears it,
// flush clears everything. Also keeps the sticky writeback-error flag.
//
// Strobe semantics: issue_valid and wr_en are single-cycle qualifiers with no
// back-pressure; each one takes effect on the rising CLK edge where it is high,
// and the issuer is expected to stall on rd_busy before raising issue_valid.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ZERO_REG = 0,
    localparam int AW      = addr_width(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_reg,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_reg,
    input  logic             flush,
    output logic [DEPTH-1:0] busy_vec,
    output logic             wb_err
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_nxt;
    logic             wb_err_q;
    logic             wr_is_zero;
    logic             err_set;

    // Writes aimed at the hard-wired zero register are never tracked.
    assign wr_is_zero = (ZERO_REG != 0) && (wr_reg == AW'(ZERO_IDX));

    // A writeback to a register with no pending producer is a pipeline bug.
    assign err_set = wr_en && !busy_q[wr_reg] && !flush && !wr_is_zero;

    // Per-register next busy state: flush beats issue, issue beats writeback
    // (a same-cycle writeback belongs to an older producer, so busy stays set).
    always_comb begin
        busy_nxt = busy_q;
        for (int r = 0; r < DEPTH; r++) begin
            if (flush) begin
                busy_nxt[r] = 1'b0;
            end else if (issue_valid && (issue_reg == AW'(r))) begin
                busy_nxt[r] = 1'b1;
            end else if (wr_en && (wr_reg == AW'(r))) begin
                busy_nxt[r] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            busy_nxt[ZERO_IDX] = 1'b0;
        end
    end

    // Busy bits and the sticky error flag; only reset clears the error.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            busy_q   <= '0;
            wb_err_q <= 1'b0;
        end else begin
            busy_q <= busy_nxt;
            if (err_set) begin
                wb_err_q <= 1'b1;
            end
        end
    end

    assign busy_vec = busy_q;
    assign wb_err   = wb_err_q;

endmodule

// File: rtl/scoreboard_reg_file.sv
// WIDTH x DEPTH register file with NUM_RD combinational read ports, optional
// hard-wired zero register, optional write-to-read bypass and a busy-bit
// scoreboard whose per-port view (rd_busy) feeds the decode stall.
module scoreboard_reg_file
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    localparam int AW      = addr_width(DEPTH)
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_busy,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_reg,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_reg,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    flush,
    output logic [DEPTH-1:0]        busy_vec,
    output logic                    wb_err
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_drop;

    // The zero register silently swallows writes.
    assign wr_drop = (ZERO_REG != 0) && (wr_reg == AW'(ZERO_IDX));

    // Data array: cleared by reset, one write port on the rising edge.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_en && !wr_drop) begin
            regs[wr_reg] <= wr_data;
        end
    end

    reg_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .wr_en       (wr_en),
        .wr_reg      (wr_reg),
        .flush       (flush),
        .busy_vec    (busy_vec),
        .wb_err      (wb_err)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        logic             busy;

        assign addr = rd_addr[i*AW +: AW];

        // Read mux: array value, overridden by a same-cycle writeback when
        // bypassing, and forced to zero/not-busy for the zero register.
        always_comb begin
            data = regs[addr];
            busy = busy_vec[addr];
            if ((BYPASS != 0) && wr_en && (wr_reg == addr)) begin
                data = wr_data;
                busy = 1'b0;
            end
            if ((ZERO_REG != 0) && (addr == AW'(ZERO_IDX))) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign rd_data[i*WIDTH +: WIDTH] = data;
        assign rd_busy[i]                = busy;
    end

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Directed bench for scoreboard_reg_file: a vector table against the default
// build (with a BYPASS=0 twin checked for data), then hand sequences for async
// reset and the zero-register build.
module tb_scoreboard_reg_file;

    logic        CLK;
    logic        RST_n;
    logic [3:0]  rd_addr;
    logic        issue_valid;
    logic [1:0]  issue_reg;
    logic        wr_en;
    logic [1:0]  wr_reg;
    logic [7:0]  wr_data;
    logic        flush;

    logic [15:0] rd_data, rd_data_nb, rd_data_z;
    logic [1:0]  rd_busy, rd_busy_nb, rd_busy_z;
    logic [3:0]  busy_vec, busy_vec_nb, busy_vec_z;
    logic        wb_err, wb_err_nb, wb_err_z;

    int tests_run;
    int tests_failed;

    scoreboard_reg_file #(.WIDTH(8), .DEPTH(4), .NUM_RD(2), .ZERO_REG(0), .BYPASS(1)) dut (
        .CLK(CLK), .RST_n(RST_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .issue_valid(issue_valid), .issue_reg(issue_reg), .wr_en(wr_en), .wr_reg(wr_reg),
        .wr_data(wr_data), .flush(flush), .busy_vec(busy_vec), .wb_err(wb_err)
    );

    scoreboard_reg_file #(.WIDTH(8), .DEPTH(4), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) dut_nb (
        .CLK(CLK), .RST_n(RST_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .issue_valid(issue_valid), .issue_reg(issue_reg), .wr_en(wr_en), .wr_reg(wr_reg),
        .wr_data(wr_data), .flush(flush), .busy_vec(busy_vec_nb), .wb_err(wb_err_nb)
    );

    scoreboard_reg_file #(.WIDTH(8), .DEPTH(4), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_z (
        .CLK(CLK), .RST_n(RST_n), .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_busy(rd_busy_z),
        .issue_valid(issue_valid), .issue_reg(issue_reg), .wr_en(wr_en), .wr_reg(wr_reg),
        .wr_data(wr_data), .flush(flush), .busy_vec(busy_vec_z), .wb_err(wb_err_z)
    );

    // Clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic       iv;
        logic [1:0] ir;
        logic       we;
        logic [1:0] wr;
        logic [7:0] wd;
        logic       fl;
        logic [1:0] a0;
        logic [1:0] a1;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [1:0] eb;
        logic [3:0] ebv;
        logic       eerr;
        logic [7:0] n0;
        logic [7:0] n1;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(
        input logic iv, input logic [1:0] ir, input logic we, input logic [1:0] wr,
        input logic [7:0] wd, input logic fl, input logic [1:0] a0, input logic [1:0] a1,
        input logic [7:0] e0, input logic [7:0] e1, input logic [1:0] eb,
        input logic [3:0] ebv, input logic eerr, input logic [7:0] n0, input logic [7:0] n1);
        vec_t v;
        v.iv = iv; v.ir = ir; v.we = we; v.wr = wr; v.wd = wd; v.fl = fl;
        v.a0 = a0; v.a1 = a1; v.e0 = e0; v.e1 = e1; v.eb = eb; v.ebv = ebv;
        v.eerr = eerr; v.n0 = n0; v.n1 = n1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [1:0] ir, input logic we,
                         input logic [1:0] wr, input logic [7:0] wd, input logic fl,
                         input logic [1:0] a0, input logic [1:0] a1);
        issue_valid = iv;
        issue_reg   = ir;
        wr_en       = we;
        wr_reg      = wr;
        wr_data     = wd;
        flush       = fl;
        rd_addr     = {a1, a0};
    endtask

    task automatic idle(input logic [1:0] a0, input logic [1:0] a1);
        drive(1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, a0, a1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        RST_n        = 1'b1;
        idle(2'd2, 2'd3);

        // Async reset: outputs must clear before any clock edge.
        @(negedge CLK);
        RST_n = 1'b0;
        #1;
        check("reset_busy_vec", 32'(busy_vec), 32'h0);
        check("reset_rd_data", 32'(rd_data), 32'h0);
        check("reset_wb_err", 32'(wb_err), 32'h0);
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);

        // Inputs: iv ir we wr wd fl a0 a1 | rd0 rd1 rd_busy busy_vec err | nobypass rd0 rd1
        vecs[0]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 2'b00, 4'b0000, 0, 8'h00, 8'h00);
        vecs[1]  = mk(1, 2, 0, 0, 8'h00, 0, 2, 3, 8'h00, 8'h00, 2'b00, 4'b0000, 0, 8'h00, 8'h00);
        vecs[2]  = mk(0, 0, 1, 2, 8'hA5, 0, 2, 0, 8'hA5, 8'h00, 2'b00, 4'b0100, 0, 8'h00, 8'h00);
        vecs[3]  = mk(0, 0, 0, 0, 8'h00, 0, 2, 2, 8'hA5, 8'hA5, 2'b00, 4'b0000, 0, 8'hA5, 8'hA5);
        vecs[4]  = mk(1, 3, 0, 0, 8'h00, 0, 3, 2, 8'h00, 8'hA5, 2'b00, 4'b0000, 0, 8'h00, 8'hA5);
        vecs[5]  = mk(0, 0, 0, 0, 8'h00, 0, 3, 1, 8'h00, 8'h00, 2'b01, 4'b1000, 0, 8'h00, 8'h00);
        vecs[6]  = mk(1, 3, 1, 3, 8'h77, 0, 3, 3, 8'h77, 8'h77, 2'b00, 4'b1000, 0, 8'h00, 8'h00);
        vecs[7]  = mk(0, 0, 0, 0, 8'h00, 0, 3, 0, 8'h77, 8'h00, 2'b01, 4'b1000, 0, 8'h77, 8'h00);
        vecs[8]  = mk(0, 0, 1, 3, 8'h88, 0, 1, 3, 8'h00, 8'h88, 2'b00, 4'b1000, 0, 8'h00, 8'h77);
        vecs[9]  = mk(1, 1, 0, 0, 8'h00, 0, 3, 1, 8'h88, 8'h00, 2'b00, 4'b0000, 0, 8'h88, 8'h00);
        vecs[10] = mk(1, 2, 0, 0, 8'h00, 0, 1, 2, 8'h00, 8'hA5, 2'b01, 4'b0010, 0, 8'h00, 8'hA5);
        vecs[11] = mk(0, 0, 0, 0, 8'h00, 1, 1, 2, 8'h00, 8'hA5, 2'b11, 4'b0110, 0, 8'h00, 8'hA5);
        vecs[12] = mk(0, 0, 0, 0, 8'h00, 0, 1, 2, 8'h00, 8'hA5, 2'b00, 4'b0000, 0, 8'h00, 8'hA5);
        vecs[13] = mk(0, 0, 1, 2, 8'h5A, 1, 2, 0, 8'h5A, 8'h00, 2'b00, 4'b0000, 0, 8'hA5, 8'h00);
        vecs[14] = mk(0, 0, 0, 0, 8'h00, 0, 2, 1, 8'h5A, 8'h00, 2'b00, 4'b0000, 0, 8'h5A, 8'h00);
        vecs[15] = mk(0, 0, 1, 1, 8'h3C, 0, 2, 1, 8'h5A, 8'h3C, 2'b00, 4'b0000, 0, 8'h5A, 8'h00);
        vecs[16] = mk(0, 0, 0, 0, 8'h00, 0, 1, 1, 8'h3C, 8'h3C, 2'b00, 4'b0000, 1, 8'h3C, 8'h3C);
        vecs[17] = mk(1, 0, 0, 0, 8'h00, 0, 0, 3, 8'h00, 8'h88, 2'b00, 4'b0000, 1, 8'h00, 8'h88);
        vecs[18] = mk(0, 0, 0, 0, 8'h00, 0, 0, 2, 8'h00, 8'h5A, 2'b01, 4'b0001, 1, 8'h00, 8'h5A);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].iv, vecs[i].ir, vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].fl,
                  vecs[i].a0, vecs[i].a1);
            #1;
            check($sformatf("v%0d_rd0", i), 32'(rd_data[7:0]), 32'(vecs[i].e0));
            check($sformatf("v%0d_rd1", i), 32'(rd_data[15:8]), 32'(vecs[i].e1));
            check($sformatf("v%0d_rd_busy", i), 32'(rd_busy), 32'(vecs[i].eb));
            check($sformatf("v%0d_busy_vec", i), 32'(busy_vec), 32'(vecs[i].ebv));
            check($sformatf("v%0d_wb_err", i), 32'(wb_err), 32'(vecs[i].eerr));
            check($sformatf("v%0d_nb_rd0", i), 32'(rd_data_nb[7:0]), 32'(vecs[i].n0));
            check($sformatf("v%0d_nb_rd1", i), 32'(rd_data_nb[15:8]), 32'(vecs[i].n1));
            @(negedge CLK);
        end

        // Mid-run async reset: busy, error and data all nonzero beforehand.
        idle(2'd2, 2'd3);
        #1;
        check("pre_reset_wb_err", 32'(wb_err), 32'h1);
        RST_n = 1'b0;
        #1;
        check("midreset_busy_vec", 32'(busy_vec), 32'h0);
        check("midreset_rd_data", 32'(rd_data), 32'h0);
        check("midreset_wb_err", 32'(wb_err), 32'h0);
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);

        // Zero-register build: write FF to reg 0 (bypass must still read 0).
        drive(1'b0, 2'd0, 1'b1, 2'd0, 8'hFF, 1'b0, 2'd0, 2'd1);
        #1;
        check("z_wr0_bypass_rd0", 32'(rd_data_z[7:0]), 32'h0);
        @(negedge CLK);
        // Issue reg 0: must never become busy.
        drive(1'b1, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0);
        #1;
        check("z_after_wr0_rd0", 32'(rd_data_z[7:0]), 32'h0);
        check("z_after_wr0_wb_err", 32'(wb_err_z), 32'h0);
        @(negedge CLK);
        idle(2'd0, 2'd0);
        #1;
        check("z_issue0_busy_vec", 32'(busy_vec_z), 32'h0);
        check("z_issue0_rd_busy", 32'(rd_busy_z), 32'h0);
        check("z_issue0_rd_data", 32'(rd_data_z), 32'h0);
        // Non-zero register still flags a stray writeback, and it sticks.
        drive(1'b0, 2'd0, 1'b1, 2'd1, 8'h11, 1'b0, 2'd1, 2'd0);
        #1;
        check("z_wr1_bypass_rd0", 32'(rd_data_z[7:0]), 32'h11);
        @(negedge CLK);
        idle(2'd1, 2'd0);
        #1;
        check("z_wr1_wb_err", 32'(wb_err_z), 32'h1);
        check("z_wr1_rd0", 32'(rd_data_z[7:0]), 32'h11);
        @(negedge CLK);
        #1;
        check("z_wb_err_sticky", 32'(wb_err_z), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
